sop_result_accumulator: RTL and testbench
=========================================

Name: sop_result_accumulator

Overview:
- Downstream consumer of the 16-bit word-level sum-of-products stage.
- Takes that stage's g results as a valid/ready stream and accumulates a frame of LEN beats, or fewer if ended by in_last, into a wide signed sum.
- Presents each completed frame sum on a valid/ready output.
- Sits between the combinational arithmetic benchmark and the result sink or checker.

Parameters:
- LEN, 4: beats per frame. Legal range 1..255.
- ACC_W, 24: accumulator and output width, >= 17.
- CNT_W, 8: width of the beat counter and out_cnt. Must hold LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort. Drops the current frame and any pending output.
- in_valid  input  1  in_g valid.
- in_ready  output  1  block accepts a beat.
- in_g  input  16  two's-complement result word from the sum-of-products stage.
- in_last  input  1  this beat ends the frame early.
- out_valid  output  1  frame result available.
- out_ready  input  1  sink accepts the result.
- out_sum  output  ACC_W  signed frame sum.
- out_cnt  output  CNT_W  number of beats in the frame.
- out_ovf  output  1  signed overflow occurred during the frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc=0; cnt=0; ovf=0.
  - out_valid=0; out_sum=0; out_cnt=0; out_ovf=0.
  - in_ready=1 on the first cycle after release.
- Beat accepted when in_valid && in_ready. The beat is sign-extended from 16 to ACC_W bits.
- IDLE: in_ready=1.
  - On accept: acc=sext(in_g), cnt=1, ovf=0.
  - If LEN==1 or in_last, go to HOLD; else go to ACC.
- ACC: in_ready=1.
  - On accept: acc=acc+sext(in_g), cnt=cnt+1.
  - When cnt+1==LEN or in_last, go to HOLD.
  - No accept: hold state.
- HOLD: in_ready=0; out_valid=1.
  - out_sum, out_cnt, out_ovf come from registers and stay stable until the handshake.
  - On out_ready: go to IDLE and clear acc, cnt, ovf. A new beat is not accepted in this same cycle.
- Latency: out_valid rises on the cycle after the final beat is accepted. Throughput is LEN beats plus one idle cycle per frame.
- Overflow: ovf sets when both addends share a sign and the sum's sign differs. It is sticky for the frame.
- Default: the sum wraps modulo 2^ACC_W.
- clr: has priority over any handshake in the same cycle.
  - Forces IDLE and clears acc, cnt, ovf.
  - Drops out_valid. The frame is discarded with no output.
- in_last in HOLD is ignored, since no beat is accepted there.
- Reset mid-frame or mid-HOLD discards all state.

Optional Feature:
- SOP_ACC_SAT_EN defined: on overflow, acc clamps to the signed maximum (2^(ACC_W-1)-1) or minimum (-2^(ACC_W-1)). Later beats continue from the clamped value. out_ovf is still set.
- Not defined: the sum wraps and out_ovf flags the wrap.
- Ports are identical in both builds.

Decomposition:
- Shared package sop_pkg:
  - state enum: IDLE, ACC, HOLD.
  - constant G_W=16.
  - function sext_g(word) to ACC_W.
  - function add_ovf(a, b) returning sum and overflow bit.
- One sub-module, sop_sat_add: ACC_W signed adder with overflow detect. Clamping sits under SOP_ACC_SAT_EN.
- The top holds the FSM, counter and output registers.

Test Plan:
- Sum of a full frame: LEN=4, ACC_W=24, beats 0x0001, 0x0002, 0x0003, 0x0004 -> out_sum=0x00000A, out_cnt=4, out_ovf=0; out_valid rises the cycle after the 4th accept.
- Negative beats: 0xFFFF x4 -> out_sum=0xFFFFFC, out_cnt=4.
- Early end: 0x0010 then 0x0020 with in_last=1 -> out_sum=0x000030, out_cnt=2.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_* stable, in_ready=0, in_valid ignored; on out_ready=1 -> IDLE next cycle.
- Overflow: ACC_W=17, 0x7FFF x4.
  - Wrap build: out_sum=0x1FFFC, out_ovf=1.
  - SOP_ACC_SAT_EN build: out_sum=0x0FFFF, out_ovf=1.
- Abort: clr pulse after 2 beats -> no out_valid. rst_n low mid-HOLD -> out_valid=0 immediately (asynchronous). A fresh frame afterwards sums correctly.

Source files
------------

// File: rtl/sop_pkg.sv
// sop_pkg - shared types and helpers for the sum-of-products result accumulator.
//
// Contents:
//   G_W        width of one sum-of-products result word (16)
//   MAX_W      widest accumulator the helpers support (64)
//   state_t    accumulator FSM states
//   sext_g     sign-extend a result word to MAX_W bits
//   add_ovf    MAX_W-bit add with signed overflow detected at a chosen MSB
//
// Helpers work at MAX_W so that any accumulator width up to 64 can share them;
// callers pass the MSB index of their own width and truncate the sum.
package sop_pkg;

  localparam int G_W   = 16;
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [MAX_W-1:0] sext_g(input logic [G_W-1:0] word);
    return {{(MAX_W-G_W){word[G_W-1]}}, word};
  endfunction

  // Returns {ovf, sum}. Overflow: both addends share a sign at bit msb and the
  // sum's bit msb differs from it.
  function automatic logic [MAX_W:0] add_ovf(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic [5:0]       msb);
    logic [MAX_W-1:0] s;
    logic             ovf;
    s   = a + b;
    ovf = (a[msb] == b[msb]) && (s[msb] != a[msb]);
    return {ovf, s};
  endfunction

endpackage

// File: rtl/sop_sat_add.sv
// sop_sat_add - ACC_W-bit signed adder with overflow flag.
//
// Ports:
//   i_a    ACC_W  running accumulator value
//   i_b    ACC_W  sign-extended incoming beat
//   o_sum  ACC_W  next accumulator value
//   o_ovf  1      signed overflow on this add
//
// Build option SOP_ACC_SAT_EN: when defined, an overflowing add clamps to the
// signed maximum or minimum; otherwise the sum wraps modulo 2^ACC_W.
// ACC_W must be in 17..64.
module sop_sat_add
  import sop_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [MAX_W-1:0] w_a_ext;
  logic [MAX_W-1:0] w_b_ext;
  logic [MAX_W:0]   w_res;
  logic [ACC_W-1:0] w_wrap;

  assign w_a_ext = MAX_W'(signed'(i_a));
  assign w_b_ext = MAX_W'(signed'(i_b));
  assign w_res   = add_ovf(w_a_ext, w_b_ext, 6'(ACC_W-1));
  assign w_wrap  = ACC_W'(w_res[MAX_W-1:0]);
  assign o_ovf   = w_res[MAX_W];

`ifdef SOP_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Overflow only happens when both operands share a sign, so i_a's sign
  // tells which rail was crossed.
  always_comb begin
    o_sum = w_wrap;
    if (w_res[MAX_W]) begin
      o_sum = i_a[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign o_sum = w_wrap;
`endif

endmodule

// File: rtl/sop_result_accumulator.sv
// sop_result_accumulator - accumulates frames of sum-of-products results.
//
// Takes 16-bit signed g results on a valid/ready stream, sums LEN beats (or
// fewer when in_last ends the frame) into an ACC_W-bit signed sum and offers
// the sum, beat count and overflow flag on a valid/ready output.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort; drops current frame and pending output
//   in_valid   in_g valid
//   in_ready   beat accepted when high
//   in_g       16-bit two's-complement result word
//   in_last    beat ends the frame early
//   out_valid  frame result available
//   out_ready  sink accepts the result
//   out_sum    ACC_W signed frame sum
//   out_cnt    CNT_W beats in the frame
//   out_ovf    signed overflow seen during the frame
//
// Build option SOP_ACC_SAT_EN (see sop_sat_add): saturating instead of
// wrapping accumulation. Ports are identical in both builds.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACC   | accumulating beats 2..LEN
// HOLD  | frame complete, result presented until out_ready
module sop_result_accumulator
  import sop_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [G_W-1:0]   in_g,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_ACC  = ST_ACC;
  localparam logic [1:0] S_HOLD = ST_HOLD;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic [ACC_W-1:0] w_g_ext;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_ovf;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_frame_end;

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign out_sum   = r_acc;
  assign out_cnt   = r_cnt;
  assign out_ovf   = r_ovf;

  assign w_accept  = in_valid && in_ready;
  assign w_g_ext   = ACC_W'(sext_g(in_g));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // r_cnt is 0 in IDLE, so the same compare covers LEN==1 there.
  assign w_frame_end = in_last || (w_cnt_inc == CNT_W'(LEN));

  sop_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_a   (r_acc),
    .i_b   (w_g_ext),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= w_g_ext;
            r_cnt   <= CNT_W'(1);
            r_ovf   <= 1'b0;
            r_state <= w_frame_end ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_add_sum;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_add_ovf;
            if (w_frame_end) begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sop_result_accumulator.sv
module tb_sop_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_g = '0;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [23:0] out_sum_a;
  logic [7:0]  out_cnt_a;

  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [16:0] out_sum_b;
  logic [7:0]  out_cnt_b;

  always #5 clk = ~clk;

  sop_result_accumulator #(.LEN(4), .ACC_W(24), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_g(in_g), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_cnt(out_cnt_a), .out_ovf(out_ovf_a)
  );

  sop_result_accumulator #(.LEN(4), .ACC_W(17), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_g(in_g), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_cnt(out_cnt_b), .out_ovf(out_ovf_b)
  );

  typedef struct {
    logic [23:0] s24;
    logic [16:0] s17;
    logic [7:0]  cnt;
    logic        ovf24;
    logic        ovf17;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [23:0] s24, input logic [16:0] s17,
                          input logic [7:0] cnt, input logic o24, input logic o17);
    exp_t e;
    e.s24 = s24; e.s17 = s17; e.cnt = cnt; e.ovf24 = o24; e.ovf17 = o17;
    sb_q.push_back(e);
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got sum %h cnt %0d with no frame expected", out_sum_a, out_cnt_a);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sum24", 32'(out_sum_a), 32'(mon_e.s24));
        chk("cnt24", 32'(out_cnt_a), 32'(mon_e.cnt));
        chk("ovf24", 32'(out_ovf_a), 32'(mon_e.ovf24));
        chk("valid17", 32'(out_valid_b), 1);
        chk("sum17", 32'(out_sum_b), 32'(mon_e.s17));
        chk("cnt17", 32'(out_cnt_b), 32'(mon_e.cnt));
        chk("ovf17", 32'(out_ovf_b), 32'(mon_e.ovf17));
      end
    end
  end

  task automatic send_beat(input logic [15:0] g, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_g = g; in_last = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_a) begin ok = 1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL beat_accept_timeout: in_ready stayed %b, required 1", in_ready_a);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
    send_beat(d, 1'b0);
    chk("latency_valid", 32'(out_valid_a), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid_a), 0);
    chk("rst_sum", 32'(out_sum_a), 0);
    chk("rst_cnt", 32'(out_cnt_a), 0);
    chk("rst_ovf", 32'(out_ovf_a), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_a), 1);
    @(posedge clk); #1;

    // full frame
    push_exp(24'h00000A, 17'h0000A, 8'd4, 1'b0, 1'b0);
    frame4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    wait_drain();

    // negative beats
    push_exp(24'hFFFFFC, 17'h1FFFC, 8'd4, 1'b0, 1'b0);
    frame4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_drain();

    // early end by in_last
    push_exp(24'h000030, 17'h00030, 8'd2, 1'b0, 1'b0);
    send_beat(16'h0010, 1'b0);
    send_beat(16'h0020, 1'b1);
    chk("latency_valid_last", 32'(out_valid_a), 1);
    wait_drain();

    // backpressure in HOLD with in_valid asserted
    out_ready = 1'b0;
    push_exp(24'h00001A, 17'h0001A, 8'd4, 1'b0, 1'b0);
    frame4(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    in_valid = 1'b1; in_g = 16'h1234; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid_a), 1);
      chk("bp_in_ready", 32'(in_ready_a), 0);
      chk("bp_sum", 32'(out_sum_a), 32'h1A);
      chk("bp_cnt", 32'(out_cnt_a), 4);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", 32'(out_valid_a), 0);
    chk("bp_idle_in_ready", 32'(in_ready_a), 1);
    chk("bp_drain", sb_q.size(), 0);

    // overflow: 24-bit copy holds it, 17-bit copy overflows
`ifdef SOP_ACC_SAT_EN
    push_exp(24'h01FFFC, 17'h0FFFF, 8'd4, 1'b0, 1'b1);
`else
    push_exp(24'h01FFFC, 17'h1FFFC, 8'd4, 1'b0, 1'b1);
`endif
    frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_drain();

    // clr after 2 beats discards the frame; next frame starts clean
    send_beat(16'h0003, 1'b0);
    send_beat(16'h0004, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clr_no_valid", 32'(out_valid_a), 0);
    end
    @(posedge clk); #1;
    push_exp(24'h000009, 17'h00009, 8'd1, 1'b0, 1'b0);
    send_beat(16'h0009, 1'b1);
    wait_drain();

    // asynchronous reset in HOLD
    out_ready = 1'b0;
    frame4(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid_a", 32'(out_valid_a), 0);
    chk("arst_valid_b", 32'(out_valid_b), 0);
    chk("arst_sum", 32'(out_sum_a), 0);
    chk("arst_cnt", 32'(out_cnt_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(in_ready_a), 1);
    @(posedge clk); #1;

    // fresh frame after reset
    push_exp(24'hFF0000, 17'h10000, 8'd2, 1'b0, 1'b0);
    send_beat(16'h8000, 1'b0);
    send_beat(16'h8000, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
